// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst SRAM, and
// hands {inst, pc} to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        start_valid;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        fs_allowin;
  logic        fs_xfer;

  assign seq_pc = fs_pc + 32'd4;
  assign nextpc = br_taken ? br_target : seq_pc;

  assign fs_allowin     = !fs_valid | ds_allowin | br_taken;
  assign inst_sram_en   = start_valid & fs_allowin;
  assign inst_sram_we   = 1'b0;
  assign inst_sram_addr = nextpc;
  assign inst_sram_wdata = 32'd0;

  assign fs_to_ds_valid = fs_valid & !br_taken;
  assign fs_xfer        = fs_to_ds_valid & ds_allowin;

  // SRAM data is only live the cycle after its read beat
  assign fs_inst      = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_bus = {fs_inst, fs_pc};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_valid <= 1'b0;
    end else begin
      start_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (inst_sram_en) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end else if (fs_xfer) begin
      fs_valid <= 1'b0;
    end
  end

  // hold the word across a stall; redirect discards it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf       <= 32'd0;
      inst_buf_valid <= 1'b0;
    end else if (br_taken | fs_xfer) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_valid & !ds_allowin & !inst_buf_valid) begin
      inst_buf       <= inst_sram_rdata;
      inst_buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: fetch-level model plus
// directed vectors with literal expectations.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hdeadbeef;
  endfunction

  // SRAM: real word after an enabled beat, garbage otherwise
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the one instruction fetch holds, and whether fetch has started
  logic        m_started;
  logic        m_valid;
  logic [31:0] m_pc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_started = 1'b0;
      m_valid   = 1'b0;
      m_pc      = RESET_PC - 32'd4;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (br_taken) begin
      m_valid = 1'b1;
      m_pc    = br_target;
    end else if (!m_valid || ds_allowin) begin
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  end

  // compare process: inputs change at negedge, settle by +3
  always begin
    @(negedge clk);
    #3;
    if (resetn === 1'b1) begin
      logic e_en, e_val;
      e_en  = m_started && (!m_valid || ds_allowin || br_taken);
      e_val = m_valid && !br_taken;
      chk("m_en", 64'(inst_sram_en), 64'(e_en));
      chk("m_valid", 64'(fs_to_ds_valid), 64'(e_val));
      if (e_en)
        chk("m_addr", 64'(inst_sram_addr),
            64'(br_taken ? br_target : m_pc + 32'd4));
      if (e_val)
        chk("m_bus", fs_to_ds_bus, {word(m_pc), m_pc});
    end
  end

  task automatic drive(input logic ds, input logic br,
                       input logic [31:0] tgt);
    @(negedge clk);
    ds_allowin = ds;
    br_taken   = br;
    br_target  = tgt;
    #4;
  endtask

  initial begin
    resetn     = 1'b0;
    ds_allowin = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("rst_en", 64'(inst_sram_en), 64'd0);
    chk("we_tie", 64'(inst_sram_we), 64'd0);
    chk("wdata_tie", 64'(inst_sram_wdata), 64'd0);

    @(negedge clk);
    resetn = 1'b1;
    ds_allowin = 1'b1;
    #4;
    chk("pre_start_en", 64'(inst_sram_en), 64'd0);

    drive(1'b1, 1'b0, 32'd0);
    chk("first_en", 64'(inst_sram_en), 64'd1);
    chk("first_addr", 64'(inst_sram_addr), 64'h1c000000);
    chk("first_nvalid", 64'(fs_to_ds_valid), 64'd0);

    drive(1'b1, 1'b0, 32'd0);
    chk("first_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("first_bus", fs_to_ds_bus, 64'hc2adbeef_1c000000);
    chk("seq_addr", 64'(inst_sram_addr), 64'h1c000004);

    drive(1'b0, 1'b0, 32'd0);
    chk("stall0_en", 64'(inst_sram_en), 64'd0);
    chk("stall0_bus", fs_to_ds_bus, 64'hc2adbeeb_1c000004);
    for (int i = 1; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      chk("stall_en", 64'(inst_sram_en), 64'd0);
      chk("stall_bus", fs_to_ds_bus, 64'hc2adbeeb_1c000004);
    end

    drive(1'b1, 1'b0, 32'd0);
    chk("release_addr", 64'(inst_sram_addr), 64'h1c000008);
    chk("release_bus", fs_to_ds_bus, 64'hc2adbeeb_1c000004);

    drive(1'b1, 1'b1, 32'h1c000100);
    chk("br_squash", 64'(fs_to_ds_valid), 64'd0);
    chk("br_addr", 64'(inst_sram_addr), 64'h1c000100);

    drive(1'b1, 1'b0, 32'd0);
    chk("br_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("br_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000100);

    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 32'h1c000200);
    chk("stbr_squash", 64'(fs_to_ds_valid), 64'd0);
    chk("stbr_en", 64'(inst_sram_en), 64'd1);
    chk("stbr_addr", 64'(inst_sram_addr), 64'h1c000200);

    drive(1'b0, 1'b0, 32'd0);
    chk("stbr_bus", fs_to_ds_bus, {word(32'h1c000200), 32'h1c000200});

    drive(1'b1, 1'b1, 32'h1c000300);
    drive(1'b1, 1'b1, 32'h1c000400);
    drive(1'b1, 1'b0, 32'd0);
    chk("b2b_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000400);

    for (int i = 0; i < 20; i++)
      drive(1'($urandom_range(0, 1)), 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);

    @(negedge clk);
    #4;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("arst_en", 64'(inst_sram_en), 64'd0);

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ds_allowin = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h1c000500;
    #4;
    chk("br_prestart", 64'(inst_sram_en), 64'd0);

    drive(1'b1, 1'b0, 32'd0);
    chk("restart_addr", 64'(inst_sram_addr), 64'h1c000000);
    drive(1'b1, 1'b0, 32'd0);
    chk("restart_bus", fs_to_ds_bus, 64'hc2adbeef_1c000000);

    drive(1'b1, 1'b0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
